share_mem_arbiter: RTL
======================

// Module: share_mem_arbiter
// PURPOSE
//  N-CPU shared-memory block with a single clock. Generalises the two-CPU dual-port share memory.
//  Each CPU gets a private write window and read access to all windows. A round-robin arbiter
//  serialises accesses onto one internal single-port RAM. A switch-board info register is readable
//  by every CPU and writable only by the owner CPU. Sits between the per-CPU bus bridges and the
//  cross-CPU mailbox software.
// PARAMETERS
//  NUM_CPU    2        number of CPU ports, 2..8
//  ADDR_W     22       word-address width per port
//  DATA_W     32       data width
//  WIN_WORDS  512      words per CPU write window, power of 2; RAM depth = NUM_CPU*WIN_WORDS
//  BASE_ADDR  22'h2000 word address of window 0; window k = BASE_ADDR+k*WIN_WORDS .. +WIN_WORDS-1
//  SWB_ADDR   22'h2400 switch-board register address; must lie outside all windows
//  SWB_RESET  32'hab   switch-board reset value
//  SWB_OWNER  0        index of the only CPU allowed to write the switch board
// PORTS
//  clk    in   1               single clock, all logic on posedge
//  rst_n  in   1               asynchronous, active-low reset
//  req    in   NUM_CPU         per-CPU access request, level
//  we     in   NUM_CPU         per-CPU 1=write 0=read, valid with req
//  addr   in   NUM_CPU*ADDR_W  flat, CPU k at [k*ADDR_W +: ADDR_W]
//  wdata  in   NUM_CPU*DATA_W  flat write data
//  ack    out  NUM_CPU         one-cycle completion pulse
//  err    out  NUM_CPU         valid with ack; 1 = access refused
//  rdata  out  NUM_CPU*DATA_W  flat read data, valid with ack, held until next ack of that port
// BEHAVIOUR
//  Reset values: ack=0, err=0, rdata=0, RR pointer=0, busy=0, switch board=SWB_RESET. RAM contents
//  are not reset. Reset asserted mid-access drops the access: no ack, no RAM write.
//  Handshake:
//   - A CPU raises req with we/addr/wdata and holds them stable until ack.
//   - Port k is eligible when req[k]=1, busy[k]=0 and ack[k]=0.
//   - Grant at edge t sets busy[k] and performs the RAM access.
//   - ack[k]=1 for exactly the cycle after t, then busy[k] clears.
//   - req still high in the cycle after ack is a new access.
//   - Latency is 1 cycle grant-to-ack. At most one grant per cycle.
//  Arbitration: round-robin. Search starts at ptr. After a grant to k, ptr = (k+1) mod NUM_CPU.
//  If nothing is eligible, ptr holds.
//  Decode, on the granted port's address:
//   - Window hit (BASE_ADDR <= a < BASE_ADDR+NUM_CPU*WIN_WORDS):
//     - RAM index = a-BASE_ADDR.
//     - Read: always allowed, rdata = RAM[index], err=0.
//     - Write: performed only if a is inside CPU k's own window, err=0. Otherwise no write, err=1.
//   - a==SWB_ADDR:
//     - Read returns the switch board, err=0.
//     - Write by SWB_OWNER updates it, err=0. A write by any other CPU is dropped, err=1.
//   - Any other address: no effect, rdata=0, err=1.
//  Ordering: accesses complete in grant order. A read granted after a write to the same address
//  returns the new data. No same-cycle RAM conflict is possible.
//  Width rules:
//   - Window-ownership compare uses RAM index bits [log2(NUM_CPU*WIN_WORDS)-1:log2(WIN_WORDS)].
//   - Range checks are done at ADDR_W bits with no wrap. An address below BASE_ADDR is a miss.
//  RAM is an inferred single-port synchronous RAM: write-first, 1-cycle read. The ack and rdata
//  registers are driven from the RAM output and switch-board mux of the granted port, captured via
//  a registered grant index.
// STRUCTURE
//  share_mem_pkg holds:
//   - the default BASE_ADDR, SWB_ADDR and SWB_RESET constants;
//   - a clog2 function;
//   - the decode result encoding (HIT_WIN, HIT_SWB, MISS).
//  Sub-module share_mem_rr_arb(NUM_CPU), purely for arbitration:
//   - inputs: eligible vector, ptr;
//   - outputs: one-hot grant, grant index, any_grant.
//  The top level holds decode, RAM, switch-board register, busy/ack/err/rdata registers and ptr.
// TESTING (NUM_CPU=2 defaults)
//  1 Reset: rst_n low -> ack=0, err=0, rdata=0. CPU0 reads 22'h2400 -> rdata=32'hab, err=0.
//  2 Own-window write/read: CPU0 writes 22'h2005=32'h1234_5678. CPU1 then reads 22'h2005
//    -> 32'h1234_5678, err=0. Each ack arrives 1 cycle after its grant.
//  3 Protection: CPU1 writes 22'h2005=32'hdead -> err=1. CPU0 then reads 22'h2005 -> still
//    32'h1234_5678. CPU1 writes 22'h2400 -> err=1 and the switch board is unchanged.
//  4 Contention: both req held high for 8 cycles with ptr=0 -> grants alternate 0,1,0,1. Each port
//    gets an ack every 2 cycles, and no cycle has two acks with the same grant.
//  5 Miss and boundary: CPU0 reads 22'h1fff and 22'h2401 -> err=1, rdata=0. CPU1 writes 22'h23ff
//    (last word) -> ok. CPU1 writes 22'h21ff -> err=1.
//  6 Reset mid-op: assert rst_n low in the grant cycle of a write -> no ack. RAM word unchanged
//    on readback. Switch board back to 32'hab.

Source files
------------

// File: rtl/share_mem_pkg.sv
// Shared constants, decode encoding and a width helper for the N-CPU share memory.
package share_mem_pkg;

  localparam int unsigned DEF_BASE_ADDR = 32'h0000_2000;
  localparam int unsigned DEF_SWB_ADDR  = 32'h0000_2400;
  localparam int unsigned DEF_SWB_RESET = 32'h0000_00ab;

  typedef enum logic [1:0] {
    HIT_WIN = 2'd0,
    HIT_SWB = 2'd1,
    MISS    = 2'd2
  } decode_e;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/share_mem_rr_arb.sv
// Round-robin pick among eligible CPU ports; search starts at ptr_i and wraps.
module share_mem_rr_arb
  import share_mem_pkg::*;
#(
  parameter  int NUM_CPU = 2,
  localparam int IDX_W   = clog2(NUM_CPU)
) (
  input  logic [NUM_CPU-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_CPU-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_gnt_o
);

  logic [NUM_CPU-1:0] upper;
  logic [NUM_CPU-1:0] masked;
  logic [NUM_CPU-1:0] pick;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    upper     = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < NUM_CPU; i++) upper[i] = (i >= int'(ptr_i));
    masked    = elig_i & upper;
    // Ports at or above the pointer win first; otherwise wrap to the lowest eligible port.
    pick      = (|masked) ? masked : elig_i;
    any_gnt_o = |elig_i;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (pick[i]) gnt_idx_o = IDX_W'(i);
    end
    for (int i = 0; i < NUM_CPU; i++) gnt_o[i] = any_gnt_o && (gnt_idx_o == IDX_W'(i));
  end

endmodule

// File: rtl/share_mem_arbiter.sv
// N-CPU shared memory: private write windows, global read, owner-only switch board,
// one round-robin access per cycle onto a single-port RAM.
module share_mem_arbiter
  import share_mem_pkg::*;
#(
  parameter int                NUM_CPU   = 2,
  parameter int                ADDR_W    = 22,
  parameter int                DATA_W    = 32,
  parameter int                WIN_WORDS = 512,
  parameter int unsigned       BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned       SWB_ADDR  = DEF_SWB_ADDR,
  parameter logic [DATA_W-1:0] SWB_RESET = DATA_W'(DEF_SWB_RESET),
  parameter int                SWB_OWNER = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CPU-1:0]        req,
  input  logic [NUM_CPU-1:0]        we,
  input  logic [NUM_CPU*ADDR_W-1:0] addr,
  input  logic [NUM_CPU*DATA_W-1:0] wdata,
  output logic [NUM_CPU-1:0]        ack,
  output logic [NUM_CPU-1:0]        err,
  output logic [NUM_CPU*DATA_W-1:0] rdata
);

  localparam int IDX_W     = clog2(NUM_CPU);
  localparam int WIN_AW    = clog2(WIN_WORDS);
  localparam int RAM_AW    = clog2(NUM_CPU * WIN_WORDS);
  localparam int RAM_DEPTH = NUM_CPU * WIN_WORDS;
  // One extra bit so the window limit never wraps at the top of the address space.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR + RAM_DEPTH);

  logic [NUM_CPU-1:0]        elig, gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      any_gnt;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [NUM_CPU-1:0]        busy_q, ack_q, err_q;
  logic [IDX_W-1:0]          idx_q;
  decode_e                   kind, kind_q;
  logic [DATA_W-1:0]         swb_q, swb_d;
  logic [NUM_CPU*DATA_W-1:0] hold_q, hold_d;

  logic [ADDR_W-1:0]         g_addr;
  logic                      g_we;
  logic [DATA_W-1:0]         g_wdata;
  logic [RAM_AW-1:0]         ram_idx;
  logic                      own, swb_ok, refuse, ram_we, ram_re;
  logic [DATA_W-1:0]         mem [RAM_DEPTH];
  logic [DATA_W-1:0]         ram_q, rd_now;

  assign elig = req & ~busy_q & ~ack_q;

  share_mem_rr_arb #(.NUM_CPU(NUM_CPU)) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  always_comb begin
    g_addr  = '0;
    g_we    = 1'b0;
    g_wdata = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        g_addr  = addr[k*ADDR_W +: ADDR_W];
        g_we    = we[k];
        g_wdata = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ram_idx = RAM_AW'(g_addr - ADDR_W'(BASE_ADDR));
    // The top index bits name the window owner.
    own     = (ram_idx[RAM_AW-1:WIN_AW] == gnt_idx);
    swb_ok  = (gnt_idx == IDX_W'(SWB_OWNER));
    if (({1'b0, g_addr} >= WIN_LO) && ({1'b0, g_addr} < WIN_HI)) kind = HIT_WIN;
    else if (g_addr == ADDR_W'(SWB_ADDR))                        kind = HIT_SWB;
    else                                                         kind = MISS;
    refuse  = (kind == MISS)
           || (g_we && (kind == HIT_WIN) && !own)
           || (g_we && (kind == HIT_SWB) && !swb_ok);
    // Reset held across the grant edge must not let the write reach the unreset RAM.
    ram_we  = any_gnt && rst_n && g_we && (kind == HIT_WIN) && own;
    ram_re  = any_gnt && !g_we && (kind == HIT_WIN);
    swb_d   = swb_q;
    if (any_gnt && g_we && (kind == HIT_SWB) && swb_ok) swb_d = g_wdata;
    ptr_d   = ptr_q;
    if (any_gnt) ptr_d = (gnt_idx == IDX_W'(NUM_CPU - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // NOTE: the RAM array has no reset; clearing it would turn the block RAM into flops.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= g_wdata;
      ram_q        <= g_wdata;
    end else if (ram_re) begin
      ram_q <= mem[ram_idx];
    end
  end

  always_comb begin
    case (kind_q)
      HIT_WIN: rd_now = ram_q;
      HIT_SWB: rd_now = swb_q;
      default: rd_now = '0;
    endcase
    hold_d = hold_q;
    rdata  = hold_q;
    for (int k = 0; k < NUM_CPU; k++) begin
      if ((|ack_q) && (idx_q == IDX_W'(k))) begin
        hold_d[k*DATA_W +: DATA_W] = rd_now;
        rdata[k*DATA_W +: DATA_W]  = rd_now;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      busy_q <= '0;
      ack_q  <= '0;
      err_q  <= '0;
      idx_q  <= '0;
      kind_q <= MISS;
      swb_q  <= SWB_RESET;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= gnt;
      ack_q  <= gnt;
      err_q  <= gnt & {NUM_CPU{refuse}};
      idx_q  <= gnt_idx;
      kind_q <= kind;
      swb_q  <= swb_d;
      hold_q <= hold_d;
    end
  end

  assign ack = ack_q;
  assign err = err_q;

endmodule
